// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_pkg
// Brief    : Shared op codes, FSM state type and operand-signedness helpers
//            for the M-extension multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package md_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_sign_fix.sv
`default_nettype none
// ============================================================================
// Module   : md_sign_fix
// Brief    : Conditional two's-complement of an N-bit value (combinational).
// Revision : 1.0 - initial release
// ============================================================================
module md_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_val,
    input  logic         i_neg,
    output logic [N-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + N'(1)) : i_val;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV M-extension unit: shift-add multiply and restoring
//            divide on magnitudes, one bit per cycle, sign fix-up at the end.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             MD_start,
    input  logic [2:0]       MD_op,
    input  logic [XLEN-1:0]  MD_a,
    input  logic [XLEN-1:0]  MD_b,
    input  logic [TAG_W-1:0] MD_tag,
    input  logic             MD_flush,
    output logic             MD_ready,
    output logic             MD_result_valid,
    output logic [XLEN-1:0]  MD_result,
    output logic [TAG_W-1:0] MD_result_tag
);

    localparam int c_CNT_W = $clog2(XLEN);

    md_state_t          r_state;
    logic [2:0]         r_op;
    logic [TAG_W-1:0]   r_tag;
    logic               r_sa;
    logic               r_sb;
    logic [XLEN-1:0]    r_mcand;
    logic [2*XLEN-1:0]  r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_valid;
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_result_tag;

    logic               w_sign_a;
    logic               w_sign_b;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_b_zero;
    logic               w_ovf;
    logic               w_fast;
    logic [XLEN-1:0]    w_fast_result;
    logic [XLEN:0]      w_add;
    logic [XLEN:0]      w_shift;
    logic [XLEN:0]      w_trial;
    logic [2*XLEN-1:0]  w_acc_next;
    logic [2*XLEN-1:0]  w_prod_fix;
    logic [XLEN-1:0]    w_quo_fix;
    logic [XLEN-1:0]    w_rem_fix;
    logic [XLEN-1:0]    w_calc_result;

    assign w_sign_a = is_signed_a(MD_op) & MD_a[XLEN-1];
    assign w_sign_b = is_signed_b(MD_op) & MD_b[XLEN-1];

    md_sign_fix #(.N(XLEN)) u_mag_a (.i_val(MD_a), .i_neg(w_sign_a), .o_val(w_mag_a));
    md_sign_fix #(.N(XLEN)) u_mag_b (.i_val(MD_b), .i_neg(w_sign_b), .o_val(w_mag_b));

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign w_b_zero = (MD_b == '0);
    assign w_ovf    = ((MD_op == MD_DIV) || (MD_op == MD_REM)) &&
                      (MD_a == {1'b1, {(XLEN-1){1'b0}}}) && (MD_b == {XLEN{1'b1}});
    assign w_fast   = MD_op[2] && (w_b_zero || w_ovf);

    always_comb begin
        w_fast_result = '0;
        if (w_b_zero)
            w_fast_result = MD_op[1] ? MD_a : {XLEN{1'b1}};
        else
            w_fast_result = MD_op[1] ? {XLEN{1'b0}} : MD_a;
    end

    // Accumulator holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign w_add   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
    assign w_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_mcand};

    always_comb begin
        w_acc_next = {w_add, r_acc[XLEN-1:1]};
        if (r_op[2]) begin
            if (w_trial[XLEN])
                w_acc_next = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            else
                w_acc_next = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
    end

    md_sign_fix #(.N(2*XLEN)) u_fix_prod (.i_val(w_acc_next), .i_neg(r_sa ^ r_sb), .o_val(w_prod_fix));
    md_sign_fix #(.N(XLEN)) u_fix_quo (.i_val(w_acc_next[XLEN-1:0]), .i_neg(r_sa ^ r_sb), .o_val(w_quo_fix));
    md_sign_fix #(.N(XLEN)) u_fix_rem (.i_val(w_acc_next[2*XLEN-1:XLEN]), .i_neg(r_sa), .o_val(w_rem_fix));

    always_comb begin
        w_calc_result = '0;
        case (r_op)
            MD_MUL:                      w_calc_result = w_prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_calc_result = w_prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             w_calc_result = w_quo_fix;
            default:                     w_calc_result = w_rem_fix;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            r_state      <= IDLE;
            r_op         <= '0;
            r_tag        <= '0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_mcand      <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_result_tag <= '0;
        end else begin
            r_valid <= 1'b0;
            if (MD_flush) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (MD_start) begin
                            r_op    <= MD_op;
                            r_tag   <= MD_tag;
                            r_sa    <= w_sign_a;
                            r_sb    <= w_sign_b;
                            r_mcand <= w_mag_b;
                            r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                            if (w_fast) begin
                                r_state      <= DONE;
                                r_valid      <= 1'b1;
                                r_result     <= w_fast_result;
                                r_result_tag <= MD_tag;
                            end else begin
                                r_state <= CALC;
                                r_cnt   <= c_CNT_W'(XLEN - 1);
                            end
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    CALC: begin
                        r_acc <= w_acc_next;
                        if (r_cnt == '0) begin
                            r_state      <= DONE;
                            r_valid      <= 1'b1;
                            r_result     <= w_calc_result;
                            r_result_tag <= r_tag;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign MD_ready        = (r_state == IDLE) || (r_state == DONE);
    assign MD_result_valid = r_valid;
    assign MD_result       = r_result;
    assign MD_result_tag   = r_result_tag;

endmodule
`default_nettype wire
